// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches six sources as level or edge
// requests, masks them and presents HWInt plus a lowest-index-first ID to CP0.
module int_ctrl #(
    parameter logic [31:0] BASE = 32'h0000_7f20,
    parameter int unsigned NSRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  irq_src,
    input  logic [31:0]      m_int_addr,
    input  logic [3:0]       m_int_byteen,
    input  logic [31:0]      m_int_wdata,
    output logic [31:0]      m_int_rdata,
    output logic [NSRC-1:0]  hw_int,
    output logic             int_valid,
    output logic [2:0]       int_id
);

    typedef enum logic [1:0] {
        REG_ACK  = 2'd0,
        REG_PEND = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_sel_e;

    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_src_q;

    logic [31:0]     w_addr_al;
    logic [31:0]     w_off;
    logic            w_hit;
    reg_sel_e        w_sel;
    logic            w_wr_any;
    logic            w_wr_b0;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_nxt;
    logic            w_unused;

    assign w_addr_al = {m_int_addr[31:2], 2'b00};
    assign w_off     = w_addr_al - BASE;
    assign w_hit     = (w_addr_al >= BASE) && (w_addr_al <= BASE + 32'd12);
    assign w_sel     = reg_sel_e'(w_off[3:2]);
    assign w_wr_any  = w_hit && (|m_int_byteen);
    assign w_wr_b0   = w_hit && m_int_byteen[0];
    assign w_unused  = ^{m_int_addr[1:0], w_off[31:4], w_off[1:0], m_int_wdata[31:NSRC]};

    // ACK clears only the external-pin request; PEND writes are write-one-to-clear.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_clr = '0;
        if (w_wr_b0 && w_sel == REG_PEND) w_clr = m_int_wdata[NSRC-1:0];
        if (w_wr_any && w_sel == REG_ACK) w_clr[2] = 1'b1;
    end

    assign w_rise     = irq_src & ~r_src_q;
    // Edge bits: a new rise wins over a same-cycle clear. Level bits simply follow the source.
    assign w_pend_nxt = (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & irq_src);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (reset) begin
            r_pend  <= '0;
            r_mask  <= '1;
            r_edge  <= NSRC'(6'b000100);
            r_src_q <= '0;
        end else begin
            r_src_q <= irq_src;
            r_pend  <= w_pend_nxt;
            if (w_wr_b0 && w_sel == REG_MASK) r_mask <= m_int_wdata[NSRC-1:0];
            if (w_wr_b0 && w_sel == REG_EDGE) r_edge <= m_int_wdata[NSRC-1:0];
        end
    end

    always_comb begin
        m_int_rdata = '0;
        if (w_hit) begin
            case (w_sel)
                REG_PEND: m_int_rdata = {{(32-NSRC){1'b0}}, r_pend};
                REG_MASK: m_int_rdata = {{(32-NSRC){1'b0}}, r_mask};
                REG_EDGE: m_int_rdata = {{(32-NSRC){1'b0}}, r_edge};
                default:  m_int_rdata = '0;
            endcase
        end
    end

    assign hw_int    = r_pend & r_mask;
    assign int_valid = |hw_int;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        int_id = 3'd7;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (hw_int[i]) int_id = 3'(i);
        end
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Memory-mapped interrupt controller between the device bus and CP0. It collects up to six hardware interrupt sources: bit0 timer0, bit1 timer1, bit2 external interrupt pin, bits 3-5 spare. It latches them as level or edge requests, masks them, and drives HWInt[5:0] plus a priority-encoded ID to CP0. Software acknowledges the external interrupt by writing to 0x7f20, the address the system bench watches to drop the interrupt pin.

Parameters:
BASE, 32'h0000_7f20, word-aligned base address of the 4-register window
NSRC, 6, number of interrupt sources (fixed at 6; HWInt width)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
irq_src  in  6  raw interrupt requests, synchronous to clk
m_int_addr  in  32  bus address, byte address
m_int_byteen  in  4  byte write enables; any bit set = write
m_int_wdata  in  32  write data
m_int_rdata  out  32  combinational read data for m_int_addr
hw_int  out  6  masked pending interrupts to CP0
int_valid  out  1  |hw_int
int_id  out  3  index of lowest set hw_int bit; 3'd7 when none

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- State on reset: pend=0, mask=6'h3f, edge=6'b000100, src_q=0. Consequently hw_int=0, int_valid=0, int_id=7.
- Register map (offset from BASE, word-aligned; addr[1:0] ignored; hit = (addr & ~3) in BASE..BASE+12):
  - +0 ACK: write with any byteen clears pend[2]. Reads 0.
  - +4 PEND: read {26'b0,pend}. Write with byteen[0] is W1C on pend[5:0].
  - +8 MASK: R/W; byteen[0] writes mask <= wdata[5:0].
  - +C EDGE: R/W; byteen[0] writes edge <= wdata[5:0]. 1=edge, 0=level.
- Non-hit addresses: m_int_rdata=0, and no write side effects.
- Sampling: src_q <= irq_src every cycle.
- Rising edge: rise = irq_src & ~src_q.
- Pending update, per bit i, each cycle:
  - Level (edge[i]=0): pend[i] <= irq_src[i]. W1C and ACK have no lasting effect while the source stays high.
  - Edge (edge[i]=1): pend[i] <= rise[i] | (pend[i] & ~clr[i]). clr = W1C bits, plus bit2 on ACK.
  - Set beats clear in the same cycle.
- Edge config change: a new edge value takes effect the cycle after the write. A bit switched to edge mode keeps its current pend value.
- Outputs: hw_int = pend & mask, combinational from registers. Latency is 1 cycle from irq_src change to hw_int. A mask write affects hw_int the next cycle.
- int_id: priority goes to the lowest index.
- Reset mid-operation: all state clears immediately and asynchronously. Outputs return to their reset values without waiting for a clock edge.
- A src_q cleared by reset while irq_src is held high produces one edge in the first cycle after reset release. This is intended behaviour.

Test Plan:
1. Reset, then read +0/+4/+8/+C -> 0, 0, 0x3f, 0x4. hw_int=0, int_id=7.
2. Pulse irq_src[2] high for 1 cycle (edge mode) -> hw_int=6'b000100 from the next cycle, held after the pulse ends, int_id=2. Write byteen=4'b0001 to 0x7f20 -> hw_int=0 the following cycle.
3. Hold irq_src[0]=1 (level) -> hw_int[0]=1. Write 1 to PEND bit0 -> hw_int[0] still 1. Drop irq_src[0] -> hw_int[0]=0 the next cycle.
4. Write MASK=0x02. Raise irq_src[0] and irq_src[1] -> hw_int=6'b000010, int_id=1. Write MASK=0x3f -> hw_int=6'b000011, int_id=0.
5. Edge mode bit2: hold irq_src[2] high and ACK in the same cycle as the rising edge -> pend[2] stays 1 (set wins). A second ACK with the source still high -> pend[2]=0, with no re-trigger until the source falls and rises again.
6. Assert reset asynchronously between clock edges with pend=0x07 -> hw_int=0 immediately. Write to 0x7f30 (outside the window) -> no register changes, rdata=0.
